mul: RTL and testbench

Sequential shift-add integer multiplier for the CPU execute stage, the counterpart of the shared sequential divider and with the same `start`/`ready` handshake. It produces the full 2×DATA_WIDTH product of two operands. Each operand is independently signed or unsigned, which covers RISC-V MUL/MULH/MULHSU/MULHU. It computes one partial product per clock. Results are held stable until the next accepted operation.

---
 rtl/mul.sv | 120 ++++++++++++
 tb/tb_mul.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mul.sv
// Sequential shift-add multiplier: full 2W-bit product, per-operand signedness, W+1 busy cycles.
// No backpressure: start edges while busy are dropped, results hold until the next accepted operation.
module mul #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [DATA_WIDTH-1:0] multiplicand,
    input  logic [DATA_WIDTH-1:0] multiplier,
    input  logic                  a_signed,
    input  logic                  b_signed,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] result_lo,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic                  ready
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [2*W-1:0]  res_q, res_d;
    logic [W-1:0]    a_mag_q, a_mag_d;
    logic            neg_q, neg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            prev_start_q, prev_start_d;

    logic            sa, sb;
    logic [W-1:0]    a_abs, b_abs;
    logic            accept;
    logic            is_zero;
    logic            last_iter;
    logic [W:0]      add_sum;

    // Operand conditioning; the most negative value maps to its unsigned magnitude.
    always_comb begin
        sa        = a_signed & multiplicand[W-1];
        sb        = b_signed & multiplier[W-1];
        a_abs     = sa ? (W'(0) - multiplicand) : multiplicand;
        b_abs     = sb ? (W'(0) - multiplier)   : multiplier;
        accept    = (state_q == ST_IDLE) & start & ~prev_start_q;
        is_zero   = (multiplicand == '0) | (multiplier == '0);
        last_iter = (cnt_q == CW'(W - 1));
        add_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, a_mag_q};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            res_q        <= '0;
            a_mag_q      <= '0;
            neg_q        <= 1'b0;
            cnt_q        <= '0;
            prev_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            res_q        <= res_d;
            a_mag_q      <= a_mag_d;
            neg_q        <= neg_d;
            cnt_q        <= cnt_d;
            prev_start_q <= prev_start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && !is_zero) state_d = ST_ITER;
            ST_ITER: if (last_iter)          state_d = ST_FIN;
            ST_FIN:                          state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_d        = acc_q;
        res_d        = res_q;
        a_mag_d      = a_mag_q;
        neg_d        = neg_q;
        cnt_d        = cnt_q;
        prev_start_d = start;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    neg_d   = sa ^ sb;
                    a_mag_d = a_abs;
                    acc_d   = {{W{1'b0}}, b_abs};
                    cnt_d   = '0;
                    if (is_zero) res_d = '0;
                end
            end
            ST_ITER: begin
                // Carry out of the add lands in the top bit after the shift.
                if (acc_q[0]) acc_d = {add_sum, acc_q[W-1:1]};
                else          acc_d = {1'b0, acc_q[2*W-1:1]};
                cnt_d = cnt_q + CW'(1);
            end
            ST_FIN: begin
                res_d = neg_q ? ((2*W)'(0) - acc_q) : acc_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        ready     = (state_q == ST_IDLE);
        result_lo = res_q[W-1:0];
        result_hi = res_q[2*W-1:W];
    end

endmodule

// File: tb/tb_mul.sv
module tb_mul;

    logic        clk;
    logic        nrst;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        a_signed;
    logic        b_signed;
    logic        start;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        ready;

    int n_chk;
    int n_pass;

    mul #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .a_signed     (a_signed),
        .b_signed     (b_signed),
        .start        (start),
        .result_lo    (result_lo),
        .result_hi    (result_hi),
        .ready        (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One operation from a single start pulse; optionally fires a stray start pulse mid-operation.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic as, input logic bs, input logic [63:0] exp,
                          input int pulse_at);
        int busy;
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        a_signed     = as;
        b_signed     = bs;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = ~a;
        multiplier   = b ^ 32'h5A5A_A5A5;
        a_signed     = ~as;
        b_signed     = ~bs;
        busy = 0;
        while (ready !== 1'b1 && busy < 200) begin
            busy++;
            if (busy == pulse_at) begin
                multiplicand = 32'h3;
                multiplier   = 32'h3;
                start        = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd33);
        chk({tag, "_hi"}, {32'h0, result_hi}, {32'h0, exp[63:32]});
        chk({tag, "_lo"}, {32'h0, result_lo}, {32'h0, exp[31:0]});
    endtask

    initial begin
        int lows;
        n_chk = 0;
        n_pass = 0;
        nrst = 1'b1;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        a_signed = 1'b0;
        b_signed = 1'b0;
        #2 nrst = 1'b0;
        #1;
        chk("rst_ready", {63'h0, ready}, 64'd1);
        chk("rst_lo", {32'h0, result_lo}, 64'd0);
        chk("rst_hi", {32'h0, result_hi}, 64'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        run_op("u7x6",   32'd7,         32'd6,         1'b0, 1'b0, 64'h0000_0000_0000_002A, -1);
        run_op("uffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, -1);
        run_op("sm1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001, -1);
        run_op("mulhsu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001, -1);
        run_op("smin2",  32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000, -1);
        run_op("sm7x6",  32'hFFFF_FFF9, 32'd6,         1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, -1);
        run_op("u2p32",  32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 64'h0000_0001_0000_0000, -1);
        run_op("pulse",  32'd7,         32'd6,         1'b0, 1'b0, 64'h0000_0000_0000_002A, 10);

        // start held high across completion must not retrigger
        @(negedge clk);
        multiplicand = 32'd7;
        multiplier   = 32'd6;
        a_signed     = 1'b0;
        b_signed     = 1'b0;
        start        = 1'b1;
        lows = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (ready === 1'b0) lows++;
            if (i == 39) start = 1'b0;
        end
        chk("hold_busy", 64'(lows), 64'd33);
        chk("hold_lo", {32'h0, result_lo}, 64'h2A);
        chk("hold_hi", {32'h0, result_hi}, 64'h0);

        // zero operand: results clear on the accept edge, no busy period
        @(negedge clk);
        multiplicand = 32'h0;
        multiplier   = 32'h1234_5678;
        start        = 1'b1;
        @(posedge clk);
        #1;
        chk("zero_ready", {63'h0, ready}, 64'd1);
        chk("zero_lo", {32'h0, result_lo}, 64'h0);
        chk("zero_hi", {32'h0, result_hi}, 64'h0);
        lows = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ready === 1'b0) lows++;
        end
        start = 1'b0;
        chk("zero_nobusy", 64'(lows), 64'd0);

        run_op("pre_rst", 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 64'h0000_0001_0000_0000, -1);

        // asynchronous reset mid-operation
        @(negedge clk);
        multiplicand = 32'd5;
        multiplier   = 32'd5;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("mid_busy", {63'h0, ready}, 64'd0);
        #2 nrst = 1'b0;
        #1;
        chk("arst_ready", {63'h0, ready}, 64'd1);
        chk("arst_lo", {32'h0, result_lo}, 64'h0);
        chk("arst_hi", {32'h0, result_hi}, 64'h0);
        @(negedge clk);
        nrst = 1'b1;
        run_op("post_rst", 32'd9, 32'd9, 1'b0, 1'b0, 64'h0000_0000_0000_0051, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
